// File: rtl/memoria_pkg.sv
// Shared constants for the main-memory model: default geometry and the
// fixed power-up/reset image used by the cache controller and its benches.
package memoria_pkg;

    localparam int MEM_ADDR_W = 4;
    localparam int MEM_DATA_W = 3;
    localparam int MEM_DEPTH  = 16;

    localparam logic [MEM_DATA_W-1:0] MEM_INIT_IMAGE [0:MEM_DEPTH-1] = '{
        3'd7, 3'd3, 3'd4, 3'd7, 3'd4, 3'd3, 3'd1, 3'd0,
        3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd0, 3'd0
    };

endpackage

// File: rtl/memoria_principal.sv
// Single-port synchronous main memory (16 x 3) with a registered,
// write-through read port. Reset reloads the image asynchronously.
module memoria_principal
    import memoria_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int DEPTH  = MEM_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem_r [0:DEPTH-1];
    logic [DATA_W-1:0] q_r;

    // Storage array and read register; a write also drives q with the new word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_r <= MEM_INIT_IMAGE;
            q_r   <= {DATA_W{1'b0}};
        end else if (wren) begin
            mem_r[address] <= data;
            q_r            <= data;
        end else begin
            q_r <= mem_r[address];
        end
    end

    assign q = q_r;

endmodule

// File: tb/tb_memoria_principal.sv
// Scoreboard bench for memoria_principal: directed scenarios plus random
// traffic checked against a plain array model of the memory.
module tb_memoria_principal;
    import memoria_pkg::*;

    logic       clock;
    logic       reset;
    logic [3:0] address;
    logic [2:0] data;
    logic       wren;
    logic [2:0] q;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0] exp;
        logic [3:0] addr;
        logic       wr;
    } exp_t;

    exp_t       sb_q[$];
    logic [2:0] model_mem [0:15];

    memoria_principal dut (
        .clock   (clock),
        .reset   (reset),
        .address (address),
        .data    (data),
        .wren    (wren),
        .q       (q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_mem[i] = MEM_INIT_IMAGE[i];
    endtask

    // One access: drive on the falling edge, predict, push after the rising edge.
    task automatic access(input logic we, input logic [3:0] a, input logic [2:0] d);
        exp_t e;
        @(negedge clock);
        wren    = we;
        address = a;
        data    = d;
        e.addr  = a;
        e.wr    = we;
        if (we) begin
            e.exp        = d;
            model_mem[a] = d;
        end else begin
            e.exp = model_mem[a];
        end
        @(posedge clock);
        #1;
        sb_q.push_back(e);
    endtask

    // Monitor: every falling edge, compare q with the oldest outstanding prediction.
    always @(negedge clock) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check(e.wr ? $sformatf("write_q[%0d]", e.addr) : $sformatf("read_q[%0d]", e.addr),
                  q, e.exp);
        end
    end

    initial begin
        reset   = 1'b1;
        wren    = 1'b0;
        address = 4'd0;
        data    = 3'd0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("reset_q", q, 3'd0);
        @(negedge clock);
        reset = 1'b0;

        // Reset then read, and full sweep of the init image
        access(1'b0, 4'd0, 3'd0);
        access(1'b0, 4'd2, 3'd0);
        access(1'b0, 4'd13, 3'd0);
        for (int i = 0; i < 16; i++) access(1'b0, 4'(i), 3'd0);

        // Write then read back, neighbour unaffected
        access(1'b1, 4'd9, 3'd5);
        access(1'b0, 4'd9, 3'd0);
        access(1'b0, 4'd8, 3'd0);

        // Write-through over the old value 7
        access(1'b1, 4'd3, 3'd6);
        access(1'b0, 4'd3, 3'd0);

        // Write-back pattern: last write wins
        access(1'b1, 4'd4, 3'd3);
        access(1'b1, 4'd4, 3'd1);
        access(1'b0, 4'd4, 3'd0);

        // Reset mid-sequence, asserted between edges
        access(1'b1, 4'd14, 3'd2);
        @(negedge clock);
        wren = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_q", q, 3'd0);
        wren    = 1'b1;
        address = 4'd14;
        data    = 3'd5;
        @(posedge clock);
        #1;
        check("write_during_reset_q", q, 3'd0);
        @(negedge clock);
        wren  = 1'b0;
        reset = 1'b0;
        model_reset();
        access(1'b0, 4'd14, 3'd0);
        access(1'b0, 4'd9, 3'd0);
        access(1'b0, 4'd3, 3'd0);
        access(1'b0, 4'd4, 3'd0);

        // Random traffic against the array model
        for (int n = 0; n < 300; n++) begin
            access(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
        end

        // Final reset restores the whole image
        @(negedge clock);
        wren  = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 16; i++) access(1'b0, 4'(i), 3'd0);

        @(negedge clock);
        @(negedge clock);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
